// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: FSM states, word width
// and the load/store opcodes used by request generators.
package mem_pkg;
  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [3:0] OP_LW = 4'b1000;
  localparam logic [3:0] OP_SW = 4'b1001;
endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, 2^ADDR_W words, registered read data.
// Contents are never reset.
module dmem_array
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    if (re) rdata <= mem[idx];
  end
endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the MEM stage: stalls the pipeline
// while an access is outstanding and strobes data_valid on completion.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        stall
);
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : '0;

  state_t            state, state_next;
  logic [3:0]        cnt, cnt_next;
  logic              lat_wr;
  logic [ADDR_W-1:0] lat_idx;
  logic [WORD_W-1:0] lat_data;
  logic              loaded;

  logic              acc_go, acc_wr;
  logic [ADDR_W-1:0] acc_idx;
  logic [WORD_W-1:0] acc_wdata;
  logic              mem_we, mem_re;
  logic [WORD_W-1:0] rdata;

  logic unused_addr;
  assign unused_addr = ^{addr[15:ADDR_W+1], addr[0]};

  // With LATENCY=1 the access happens at the acceptance edge, so the live
  // request fields are routed to the array instead of the latches.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    stall      = 1'b0;
    acc_go     = 1'b0;
    acc_wr     = lat_wr;
    acc_idx    = lat_idx;
    acc_wdata  = lat_data;
    case (state)
      IDLE: begin
        stall = enable;
        if (enable) begin
          if (LATENCY == 1) begin
            state_next = DONE;
            acc_go     = 1'b1;
            acc_wr     = wr;
            acc_idx    = addr[ADDR_W:1];
            acc_wdata  = data_in;
          end else begin
            state_next = BUSY;
            cnt_next   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt == '0) begin
          acc_go     = 1'b1;
          state_next = DONE;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign mem_we = acc_go & acc_wr & ~rst;
  assign mem_re = acc_go & ~acc_wr & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      data_valid <= 1'b0;
      loaded     <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      data_valid <= (state_next == DONE);
      if (mem_re) loaded <= 1'b1;
      if (state == IDLE && enable) begin
        lat_wr   <= wr;
        lat_idx  <= addr[ADDR_W:1];
        lat_data <= data_in;
      end
    end
  end

  // The array's read register has no reset; reported data is zero until the
  // first load after reset completes.
  assign data_out = loaded ? rdata : '0;

  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .idx   (acc_idx),
    .wdata (acc_wdata),
    .rdata (rdata)
  );
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: cycle-by-cycle vector table on a LATENCY=4 instance,
// plus hand-written back-to-back and LATENCY=1 sequences.
module tb_dmem_responder;
  import mem_pkg::*;

  localparam logic [3:0] OP_NONE = 4'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en4 = 1'b0, wr4 = 1'b0;
  logic [15:0] addr4 = '0, din4 = '0, dout4;
  logic        dv4, st4;
  logic        en1 = 1'b0, wr1 = 1'b0;
  logic [15:0] addr1 = '0, din1 = '0, dout1;
  logic        dv1, st1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(10), .LATENCY(4)) u4 (
    .clk(clk), .rst(rst), .enable(en4), .wr(wr4), .addr(addr4),
    .data_in(din4), .data_out(dout4), .data_valid(dv4), .stall(st4)
  );

  dmem_responder #(.ADDR_W(10), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .enable(en1), .wr(wr1), .addr(addr1),
    .data_in(din1), .data_out(dout1), .data_valid(dv1), .stall(st1)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  op;
    logic [15:0] addr;
    logic [15:0] din;
    logic        st;
    logic        dv;
    logic [15:0] dout;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic r, logic [3:0] op, logic [15:0] a, logic [15:0] d,
                              logic s, logic v, logic [15:0] o);
    vec_t x;
    x.rst = r; x.op = op; x.addr = a; x.din = d; x.st = s; x.dv = v; x.dout = o;
    vecs.push_back(x);
  endfunction

  task automatic chk(input string name, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  // Hold a request for the request cycle plus LATENCY-1 busy cycles, then DONE.
  function automatic void access4(logic [3:0] op, logic [15:0] a, logic [15:0] d,
                                  logic [15:0] old, logic [15:0] fin);
    for (int i = 0; i < 4; i++) add(1'b0, op, a, d, 1'b1, 1'b0, old);
    add(1'b0, op, a, d, 1'b0, 1'b1, fin);
    add(1'b0, OP_NONE, '0, '0, 1'b0, 1'b0, fin);
  endfunction

  initial begin
    int pulses, first_c, second_c;
    logic [15:0] first_d, second_d;

    // reset state
    add(1'b1, OP_NONE, '0, '0, 1'b0, 1'b0, 16'h0000);
    // store leaves data_out alone; load with addr bit 0 set
    access4(OP_SW, 16'h0010, 16'hBEEF, 16'h0000, 16'h0000);
    access4(OP_LW, 16'h0011, 16'h0000, 16'h0000, 16'hBEEF);
    // inputs changed during BUSY are ignored
    add(1'b0, OP_SW, 16'h0020, 16'h5A5A, 1'b1, 1'b0, 16'hBEEF);
    for (int i = 0; i < 3; i++) add(1'b0, OP_SW, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hBEEF);
    add(1'b0, OP_SW, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hBEEF);
    add(1'b0, OP_NONE, '0, '0, 1'b0, 1'b0, 16'hBEEF);
    access4(OP_LW, 16'h0020, 16'h0000, 16'hBEEF, 16'h5A5A);
    // reset in cycle 2 of a store aborts it
    access4(OP_SW, 16'h0030, 16'h7777, 16'h5A5A, 16'h5A5A);
    add(1'b0, OP_SW, 16'h0030, 16'h1234, 1'b1, 1'b0, 16'h5A5A);
    add(1'b0, OP_SW, 16'h0030, 16'h1234, 1'b1, 1'b0, 16'h5A5A);
    add(1'b1, OP_SW, 16'h0030, 16'h1234, 1'b1, 1'b0, 16'h5A5A);
    for (int i = 0; i < 3; i++) add(1'b0, OP_NONE, '0, '0, 1'b0, 1'b0, 16'h0000);
    access4(OP_LW, 16'h0030, 16'h0000, 16'h0000, 16'h7777);
    // reset together with a new request: not accepted
    add(1'b1, OP_LW, 16'h0010, 16'h0000, 1'b1, 1'b0, 16'h7777);
    add(1'b0, OP_NONE, '0, '0, 1'b0, 1'b0, 16'h0000);
    add(1'b0, OP_NONE, '0, '0, 1'b0, 1'b0, 16'h0000);

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      rst   = vecs[i].rst;
      en4   = (vecs[i].op == OP_LW) || (vecs[i].op == OP_SW);
      wr4   = (vecs[i].op == OP_SW);
      addr4 = vecs[i].addr;
      din4  = vecs[i].din;
      @(negedge clk);
      chk("stall", i, {15'b0, st4}, {15'b0, vecs[i].st});
      chk("data_valid", i, {15'b0, dv4}, {15'b0, vecs[i].dv});
      chk("data_out", i, dout4, vecs[i].dout);
    end

    // back-to-back loads with enable held through DONE
    pulses = 0; first_c = -1; second_c = -1; first_d = '0; second_d = '0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin en4 = 1'b1; wr4 = 1'b0; addr4 = 16'h0010; end
      if (c == 5) addr4 = 16'h0020;
      if (c == 10) en4 = 1'b0;
      @(negedge clk);
      if (dv4) begin
        pulses++;
        if (first_c < 0) begin first_c = c; first_d = dout4; end
        else if (second_c < 0) begin second_c = c; second_d = dout4; end
      end
    end
    chk("b2b_pulses", 0, 16'(pulses), 16'd2);
    chk("b2b_first_cycle", 0, 16'(first_c), 16'd4);
    chk("b2b_gap", 0, 16'(second_c - first_c), 16'd5);
    chk("b2b_first_data", 0, first_d, 16'hBEEF);
    chk("b2b_second_data", 0, second_d, 16'h5A5A);

    // LATENCY=1 instance, with address aliasing above ADDR_W
    @(negedge clk);
    chk("l1_reset_dout", 0, dout1, 16'h0000);
    chk("l1_reset_stall", 0, {15'b0, st1}, 16'h0000);
    @(posedge clk); #1;
    en1 = 1'b1; wr1 = 1'b1; addr1 = 16'h0802; din1 = 16'hCAFE;
    @(negedge clk);
    chk("l1_sw_stall", 0, {15'b0, st1}, 16'h0001);
    chk("l1_sw_valid", 0, {15'b0, dv1}, 16'h0000);
    @(posedge clk); #1;
    en1 = 1'b0;
    @(negedge clk);
    chk("l1_sw_stall", 1, {15'b0, st1}, 16'h0000);
    chk("l1_sw_valid", 1, {15'b0, dv1}, 16'h0001);
    chk("l1_sw_dout", 1, dout1, 16'h0000);
    @(posedge clk); #1;
    en1 = 1'b1; wr1 = 1'b0; addr1 = 16'h0002;
    @(negedge clk);
    chk("l1_lw_stall", 0, {15'b0, st1}, 16'h0001);
    chk("l1_lw_valid", 0, {15'b0, dv1}, 16'h0000);
    @(posedge clk); #1;
    @(negedge clk);
    chk("l1_lw_stall", 1, {15'b0, st1}, 16'h0000);
    chk("l1_lw_valid", 1, {15'b0, dv1}, 16'h0001);
    chk("l1_lw_dout", 1, dout1, 16'hCAFE);
    @(posedge clk); #1;
    en1 = 1'b0;
    @(negedge clk);
    chk("l1_idle_valid", 0, {15'b0, dv1}, 16'h0000);
    chk("l1_hold_dout", 0, dout1, 16'hCAFE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder that services the CPU MEM stage's load/store requests (`enable`, `wr`, `addr`, `data_in`) with a fixed, parameterised access latency. It raises `stall` to freeze the pipeline while an access is outstanding. It returns read data with a one-cycle `data_valid` strobe. It replaces the single-cycle data memory so the pipeline's stall path is exercised against realistic memory timing.

## Interface
Parameters:
- `ADDR_W`, default 10: word-address width; the array holds 2^ADDR_W 16-bit words.
- `LATENCY`, default 4: cycles from the request cycle to the `data_valid` cycle; legal range 1..15.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `enable`, input, 1: request present (LW or SW in EX/MEM).
- `wr`, input, 1: 1 = store, 0 = load; qualified by `enable`.
- `addr`, input, 16: byte address; bit 0 ignored; word index = `addr[ADDR_W:1]`; higher bits ignored (aliasing).
- `data_in`, input, 16: store data.
- `data_out`, output, 16: most recent load result; held between loads.
- `data_valid`, output, 1: one-cycle strobe; access completed this cycle.
- `stall`, output, 1: pipeline must hold EX/MEM and earlier stages this cycle.

## Operation
- FSM states:
  - IDLE: no access outstanding.
  - BUSY: latency countdown.
  - DONE: completion cycle.
- IDLE with `enable`=1: latch `wr`, word index and `data_in`.
  - `LATENCY`=1: go to DONE.
  - Otherwise: load the countdown with `LATENCY`-2 and go to BUSY.
- IDLE with `enable`=0: remain in IDLE.
- BUSY: count down. At the edge where the count is 0, perform the array access (write latched data, or read latched word into `data_out`) and go to DONE.
- DONE: `data_valid`=1. Go to IDLE at the next edge unconditionally. `enable` is ignored in DONE, because it still reflects the request being retired.
- `stall`:
  - `stall` = (IDLE and `enable`) or BUSY. It is combinational on `enable` in IDLE, so the request cycle itself stalls.
  - `stall`=0 in DONE, so the pipeline advances at the end of the DONE cycle.
- `data_out` updates only on completion of a load. Stores leave it unchanged.
- Input changes after acceptance are ignored. Only latched values are used.
- Back-to-back requests: a new `enable` in the cycle after DONE is accepted normally. Sustained throughput is one access per `LATENCY`+1 cycles.
- Reset: state goes to IDLE, countdown to 0, `data_out` to 0, `data_valid` to 0.
  - `stall` follows the IDLE equation, so it is 0 unless `enable` is high.
  - Array contents are not reset.
  - Reset during BUSY aborts the access; a pending store is discarded and the array is unmodified.
  - Reset asserted in the same cycle as a new request: reset wins and the request is not accepted.

## Timing
- Request present in cycle 0 (IDLE, `enable`=1) → `data_valid`=1 in cycle `LATENCY`, and `stall`=1 in cycles 0..`LATENCY`-1.
- `LATENCY`=1: request in cycle 0, `data_valid` in cycle 1, `stall` high only in cycle 0.
- Read data is visible on `data_out` in the `data_valid` cycle and is held until the next load completes.
- A store is committed at the edge entering DONE. A load accepted in the cycle after that DONE observes the new value.
- All outputs except `stall` are registered.

## Structure
- Shared package `mem_pkg`:
  - state enum `{IDLE, BUSY, DONE}`;
  - `WORD_W`=16;
  - the LW/SW opcode constants 4'b1000 and 4'b1001 for the bench's request generator.
- Sub-module `dmem_array`: single-port synchronous RAM, 2^ADDR_W × 16. Ports: `clk`, `we`, `re`, `idx`, `wdata`, `rdata`. Read data is registered. No reset on contents.
- Top level holds the FSM, the 4-bit countdown, and the request latches.

## Test plan
- `LATENCY`=4. SW `addr`=0x0010 `data_in`=0xBEEF in cycle 0 → `stall`=1 in cycles 0–3; `data_valid`=1 in cycle 4; `data_out` unchanged (0x0000 after reset).
- Then LW `addr`=0x0011 (bit 0 ignored) → `data_out`=0xBEEF with `data_valid` four cycles after the request.
- Back-to-back LW/LW with `enable` held high through DONE → exactly two `data_valid` pulses, 5 cycles apart; no spurious third access.
- Change `addr` and `data_in` to 0xFFFF during BUSY of a SW to 0x0020 → word 0x10 receives the latched data; the address 0xFFFF aliases nothing.
- Assert `rst` in cycle 2 of a SW 0x1234 to 0x0030 → state IDLE, `stall`=0, no `data_valid`; subsequent LW 0x0030 returns prior contents.
- `LATENCY`=1 build: LW request in cycle 0 → `stall` high one cycle, `data_valid` in cycle 1. Aliasing check: SW `addr`=0x0802 then LW 0x0002 with `ADDR_W`=10 → same word returned.
